// File: rtl/sweep_pkg.sv
// Shared types and default timing for the PLL sweep sequencer.
package sweep_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned STEP_W  = 4;
  localparam int unsigned COUNT_W = 9;
  localparam int unsigned TIMER_W = 32;

  localparam int unsigned DEF_DWELL_CYCLES = 50_000_000;
  localparam int unsigned DEF_NUM_STEPS    = 511;
  localparam int unsigned DEF_BLANK_CYCLES = 4;
  localparam int unsigned DEF_LOCK_TIMEOUT = 1_000_000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_REQUEST   = 3'd1,
    ST_BLANK     = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_DWELL     = 3'd4,
    ST_ERROR     = 3'd5
  } state_e;

endpackage

// File: rtl/cycle_timer.sv
// Up-counter with synchronous clear and a terminal-count flag; saturates at the
// terminal value so it can never wrap.
module cycle_timer
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] tc_value_i,
  output logic             tc_c
);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc_c = (count_q == tc_value_i);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !tc_c) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sweep_sequencer.sv
// Automatic PLL sweep sequencer: issues step requests, waits for lock, dwells,
// and repeats for a programmed number of steps in single-pass or continuous mode.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int unsigned NUM_STEPS    = DEF_NUM_STEPS,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic               CLK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [STEP_W-1:0]  step_in,
  input  logic               freq_ready,
  output logic               next_frequency,
  output logic [STEP_W-1:0]  step_out,
  output logic               busy,
  output logic               sweep_done,
  output logic               timeout_err,
  output logic [COUNT_W-1:0] step_count,
  output logic [STATE_W-1:0] curr_state
);

  localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(NUM_STEPS);

  state_e               state_q, state_d;
  logic [STEP_W-1:0]    step_out_q, step_out_d;
  logic                 cont_q, cont_d;
  logic [COUNT_W-1:0]   step_count_q, step_count_d;
  logic                 next_frequency_q, next_frequency_d;
  logic                 busy_q, busy_d;
  logic                 sweep_done_q, sweep_done_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [TIMER_W-1:0]   tc_value;
  logic                 timer_en;
  logic                 timer_clr;
  logic                 timer_tc_c;

  // One timer serves BLANK, WAIT_LOCK and DWELL; it restarts on every state change.
  always_comb begin
    tc_value = TIMER_W'(DWELL_CYCLES - 1);
    case (state_q)
      ST_BLANK:     tc_value = TIMER_W'(BLANK_CYCLES - 1);
      ST_WAIT_LOCK: tc_value = TIMER_W'(LOCK_TIMEOUT - 1);
      default:      tc_value = TIMER_W'(DWELL_CYCLES - 1);
    endcase
  end

  assign timer_en  = state_q inside {ST_BLANK, ST_WAIT_LOCK, ST_DWELL};
  assign timer_clr = (state_d != state_q);

  cycle_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk        (CLK_50),
    .reset      (reset),
    .clear_i    (timer_clr),
    .en_i       (timer_en),
    .tc_value_i (tc_value),
    .tc_c       (timer_tc_c)
  );

  // Next-state and registered-output decode; step_count counts the request being issued.
  always_comb begin
    state_d       = state_q;
    step_out_d    = step_out_q;
    cont_d        = cont_q;
    step_count_d  = step_count_q;
    sweep_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d       = ST_REQUEST;
          step_out_d    = step_in;
          cont_d        = continuous;
          step_count_d  = COUNT_W'(1);
          timeout_err_d = 1'b0;
        end
      end
      ST_REQUEST: state_d = ST_BLANK;
      ST_BLANK: begin
        if (timer_tc_c) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (freq_ready) begin
          state_d = ST_DWELL;
        end else if (timer_tc_c) begin
          state_d       = ST_ERROR;
          timeout_err_d = 1'b1;
        end
      end
      ST_DWELL: begin
        if (timer_tc_c) begin
          if (step_count_q < LAST_STEP) begin
            state_d      = ST_REQUEST;
            step_count_d = step_count_q + COUNT_W'(1);
          end else begin
            sweep_done_d = 1'b1;
            if (cont_q) begin
              state_d      = ST_REQUEST;
              step_count_d = COUNT_W'(1);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase

    // Abort overrides any transition decided above.
    if (stop && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      step_count_d  = step_count_q;
      sweep_done_d  = 1'b0;
      timeout_err_d = timeout_err_q;
    end

    next_frequency_d = (state_d == ST_REQUEST);
    busy_d           = state_d inside {ST_REQUEST, ST_BLANK, ST_WAIT_LOCK, ST_DWELL};
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      step_out_q       <= '0;
      cont_q           <= 1'b0;
      step_count_q     <= '0;
      next_frequency_q <= 1'b0;
      busy_q           <= 1'b0;
      sweep_done_q     <= 1'b0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      step_out_q       <= step_out_d;
      cont_q           <= cont_d;
      step_count_q     <= step_count_d;
      next_frequency_q <= next_frequency_d;
      busy_q           <= busy_d;
      sweep_done_q     <= sweep_done_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

  assign next_frequency = next_frequency_q;
  assign step_out       = step_out_q;
  assign busy           = busy_q;
  assign sweep_done     = sweep_done_q;
  assign timeout_err    = timeout_err_q;
  assign step_count     = step_count_q;
  assign curr_state     = state_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer with a cycle-stamped scoreboard of expected
// request pulses and sweep_done pulses.
module tb_sweep_sequencer;

  logic       CLK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       continuous = 1'b0;
  logic [3:0] step_in = 4'd0;
  logic       freq_ready = 1'b0;
  logic       next_frequency;
  logic [3:0] step_out;
  logic       busy;
  logic       sweep_done;
  logic       timeout_err;
  logic [8:0] step_count;
  logic [2:0] curr_state;

  typedef struct {
    int unsigned cyc;
    logic [8:0]  cnt;
  } pulse_t;

  pulse_t      pq[$];
  int unsigned dq[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          mode = 0;
  int          wl_cnt = 0;
  bit          exp_nf;
  bit          exp_sd;

  sweep_sequencer #(
    .DWELL_CYCLES (10),
    .NUM_STEPS    (3),
    .BLANK_CYCLES (4),
    .LOCK_TIMEOUT (100)
  ) dut (
    .CLK_50         (CLK_50),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .continuous     (continuous),
    .step_in        (step_in),
    .freq_ready     (freq_ready),
    .next_frequency (next_frequency),
    .step_out       (step_out),
    .busy           (busy),
    .sweep_done     (sweep_done),
    .timeout_err    (timeout_err),
    .step_count     (step_count),
    .curr_state     (curr_state)
  );

  always #5 CLK_50 = ~CLK_50;

  always @(posedge CLK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_50);
  endtask

  task automatic push_pulse(input int unsigned c, input int unsigned n);
    pulse_t p;
    p.cyc = c;
    p.cnt = 9'(n);
    pq.push_back(p);
  endtask

  // PLL model: 0 never locks, 1 always locked, 2 locks on the third WAIT_LOCK cycle.
  always @(negedge CLK_50) begin
    if (curr_state == 3'd3) wl_cnt = wl_cnt + 1;
    else wl_cnt = 0;
    freq_ready = (mode == 1) || ((mode == 2) && (curr_state == 3'd3) && (wl_cnt >= 3));
  end

  // Scoreboard: every request/sweep_done pulse must land on its predicted cycle.
  always @(negedge CLK_50) begin
    exp_nf = (pq.size() != 0) && (pq[0].cyc == cyc);
    exp_sd = (dq.size() != 0) && (dq[0] == cyc);
    if (next_frequency || exp_nf) begin
      chk("next_frequency", 32'(next_frequency), 32'(exp_nf));
      if (exp_nf) begin
        chk("step_count_at_pulse", 32'(step_count), 32'(pq[0].cnt));
        void'(pq.pop_front());
      end
    end
    if (sweep_done || exp_sd) begin
      chk("sweep_done", 32'(sweep_done), 32'(exp_sd));
      if (exp_sd) void'(dq.pop_front());
    end
  end

  initial begin
    int unsigned n;

    // Reset values
    tick(2);
    chk("rst_state", 32'(curr_state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_step_out", 32'(step_out), 0);
    chk("rst_step_count", 32'(step_count), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    reset = 1'b0;
    tick(2);

    // Single pass, lock two cycles after blanking
    mode = 2;
    continuous = 1'b0;
    step_in = 4'd5;
    start = 1'b1;
    n = cyc;
    push_pulse(n + 1, 1);
    push_pulse(n + 19, 2);
    push_pulse(n + 37, 3);
    dq.push_back(n + 55);
    tick(1);
    start = 1'b0;
    chk("p1_busy", 32'(busy), 1);
    chk("p1_state_req", 32'(curr_state), 1);
    tick(59);
    chk("p1_state_idle", 32'(curr_state), 0);
    chk("p1_busy_end", 32'(busy), 0);
    chk("p1_step_count", 32'(step_count), 3);
    chk("p1_step_out", 32'(step_out), 5);
    chk("p1_pq_empty", 32'(pq.size()), 0);
    chk("p1_dq_empty", 32'(dq.size()), 0);

    // Continuous mode: step_count wraps 3 -> 1, sweep_done every third request
    continuous = 1'b1;
    step_in = 4'd2;
    start = 1'b1;
    n = cyc;
    for (int k = 0; k < 7; k++) push_pulse(n + 1 + 18 * k, (k % 3) + 1);
    dq.push_back(n + 55);
    dq.push_back(n + 109);
    tick(1);
    start = 1'b0;
    continuous = 1'b0;
    tick(111);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("p2_state_idle", 32'(curr_state), 0);
    chk("p2_step_count", 32'(step_count), 1);
    chk("p2_busy", 32'(busy), 0);
    chk("p2_pq_empty", 32'(pq.size()), 0);
    chk("p2_dq_empty", 32'(dq.size()), 0);
    tick(2);

    // Lock never arrives: timeout into ERROR, stop, then restart clears the error
    mode = 0;
    start = 1'b1;
    n = cyc;
    push_pulse(n + 1, 1);
    tick(1);
    start = 1'b0;
    tick(104);
    chk("p3_still_waiting", 32'(curr_state), 3);
    chk("p3_no_err_yet", 32'(timeout_err), 0);
    tick(1);
    chk("p3_state_error", 32'(curr_state), 5);
    chk("p3_timeout_err", 32'(timeout_err), 1);
    chk("p3_busy_err", 32'(busy), 0);
    tick(2);
    chk("p3_err_held", 32'(curr_state), 5);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("p3_stop_idle", 32'(curr_state), 0);
    chk("p3_err_sticky", 32'(timeout_err), 1);
    start = 1'b1;
    push_pulse(cyc + 1, 1);
    tick(1);
    start = 1'b0;
    chk("p3_err_cleared", 32'(timeout_err), 0);
    chk("p3_restart_busy", 32'(busy), 1);
    tick(1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("p3_abort_idle", 32'(curr_state), 0);
    tick(2);

    // Lock stuck high: BLANK still four cycles, DWELL after one WAIT_LOCK cycle
    mode = 1;
    start = 1'b1;
    n = cyc;
    push_pulse(n + 1, 1);
    push_pulse(n + 17, 2);
    tick(1);
    start = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      chk("p4_blank", 32'(curr_state), 2);
      tick(1);
    end
    chk("p4_wait_one", 32'(curr_state), 3);
    tick(1);
    chk("p4_dwell", 32'(curr_state), 4);
    tick(11);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("p4_idle", 32'(curr_state), 0);
    chk("p4_step_count", 32'(step_count), 2);
    chk("p4_pq_empty", 32'(pq.size()), 0);
    tick(2);

    // Stop during DWELL of step 2; then start and stop together stay idle
    mode = 2;
    start = 1'b1;
    n = cyc;
    push_pulse(n + 1, 1);
    push_pulse(n + 19, 2);
    tick(1);
    start = 1'b0;
    tick(29);
    chk("p5_in_dwell", 32'(curr_state), 4);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("p5_idle", 32'(curr_state), 0);
    chk("p5_step_count", 32'(step_count), 2);
    chk("p5_busy", 32'(busy), 0);
    tick(40);
    chk("p5_pq_empty", 32'(pq.size()), 0);
    chk("p5_dq_empty", 32'(dq.size()), 0);
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    chk("p5_start_stop_idle", 32'(curr_state), 0);
    chk("p5_start_stop_busy", 32'(busy), 0);
    tick(2);

    // Reset in WAIT_LOCK; step_in changes while busy are ignored
    mode = 0;
    step_in = 4'd9;
    start = 1'b1;
    push_pulse(cyc + 1, 1);
    tick(1);
    start = 1'b0;
    chk("p6_step_out", 32'(step_out), 9);
    tick(1);
    step_in = 4'd3;
    tick(6);
    chk("p6_wait_lock", 32'(curr_state), 3);
    chk("p6_step_out_held", 32'(step_out), 9);
    reset = 1'b1;
    tick(1);
    chk("p6_rst_state", 32'(curr_state), 0);
    chk("p6_rst_busy", 32'(busy), 0);
    chk("p6_rst_nf", 32'(next_frequency), 0);
    chk("p6_rst_step_out", 32'(step_out), 0);
    chk("p6_rst_step_count", 32'(step_count), 0);
    chk("p6_rst_timeout_err", 32'(timeout_err), 0);
    chk("p6_rst_sweep_done", 32'(sweep_done), 0);
    reset = 1'b0;
    tick(20);
    chk("p6_stay_idle", 32'(curr_state), 0);
    chk("p6_pq_empty", 32'(pq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
